// File: rtl/mircore_isa_pkg.sv
// mircore_isa_pkg
//   Shared ISA and fetch-stage definitions for the mircore BIOS path.
//   - OP_HLT / OP_JUMP : opcode values found in bits [31:26] of a word.
//   - op_of()          : extracts the opcode field from an instruction word.
//   - fetch_state_t    : fetch FSM state type with its four state constants.
package mircore_isa_pkg;

    localparam logic [5:0] OP_HLT  = 6'b011101;
    localparam logic [5:0] OP_JUMP = 6'b011010;

    // Opcode occupies the top six bits of every instruction word.
    function automatic logic [5:0] op_of(input logic [31:0] word);
        return word[31:26];
    endfunction

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_ISSUE   = 2'd0;
    localparam fetch_state_t S_CAPTURE = 2'd1;
    localparam fetch_state_t S_PRESENT = 2'd2;
    localparam fetch_state_t S_HALT    = 2'd3;

endpackage

// File: rtl/bios_fetch.sv
// bios_fetch
//   Fetch stage in front of the BIOS ROM. Owns the program counter, drives the
//   ROM word address, captures the ROM's registered output and presents each
//   word to the decoder with a valid/ready handshake. One word is in flight at
//   a time (issue -> capture -> present), so a steady stream costs 3 cycles
//   per instruction. Fetch stops on an accepted HLT word (halted) or when the
//   PC leaves the BIOS image (fault); only reset restarts it.
//
//   Optional build macro: BIOS_FETCH_PREDECODE_EN
//     When defined, an accepted JUMP word with no concurrent redirect sends the
//     PC to its zero-extended 26-bit target instead of pc+1.
//
// Ports
//   clk_auto     in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   address      out  ROM word address (the pc register)
//   biosOut      in   ROM data, valid the cycle after address is sampled
//   redirect_en  in   control unit requests a PC change
//   redirect_pc  in   redirect target
//   instr        out  held instruction word
//   instr_pc     out  PC the held word came from
//   instr_valid  out  instr/instr_pc valid
//   instr_ready  in   decoder accepts instr this cycle
//   halted       out  fetch stopped by HLT
//   fault        out  fetch stopped by out-of-range PC
module bios_fetch
    import mircore_isa_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BIOS_DEPTH = 64,
    parameter int RESET_PC   = 0
) (
    input  logic              clk_auto,
    input  logic              reset,
    output logic [ADDR_W-1:0] address,
    input  logic [31:0]       biosOut,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(BIOS_DEPTH);
    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] seq_pc;

    // PC used after an accepted word when no redirect is present. The +1
    // wraps naturally; an out-of-range result is caught at the next issue.
    always_comb begin
        seq_pc = pc_q + ADDR_W'(1);
`ifdef BIOS_FETCH_PREDECODE_EN
        if (op_of(instr_q) == OP_JUMP) begin
            seq_pc = ADDR_W'(instr_q[25:0]);
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        fault_d    = fault_q;

        if (state_q != S_HALT && redirect_en) begin
            // A redirect in any running state discards whatever is in flight
            // or held; if the decoder accepted the same cycle, the held word
            // simply counts as consumed and its opcode is not examined.
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = S_ISSUE;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (pc_q >= DEPTH_W) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        // address is pc_q; the ROM samples it on this edge.
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    instr_d    = biosOut;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = S_PRESENT;
                end
                S_PRESENT: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        if (op_of(instr_q) == OP_HLT) begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            pc_d    = seq_pc;
                            state_d = S_ISSUE;
                        end
                    end
                end
                default: begin
                    // S_HALT: frozen until reset.
                    state_d = S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_auto) begin
        if (reset) begin
            state_q    <= S_ISSUE;
            pc_q       <= PC_RST;
            instr_q    <= 32'd0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign address     = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_bios_fetch.sv
// tb_bios_fetch
//   Bench for bios_fetch: a 64-word registered-read ROM model, a cycle table
//   for the reset/throughput/stall sequence, hand-written sequences for
//   redirect, HLT, fault and jump predecode, and a randomized run checked
//   against a transaction-level model of which word must be presented next.
module tb_bios_fetch;

    localparam logic [5:0] T_HLT  = 6'b011101;
    localparam logic [5:0] T_JUMP = 6'b011010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] bios_out;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic        fault;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [64];

    always #5 clk = ~clk;

    // ROM with registered read; out-of-range addresses read as zero.
    always @(posedge clk) begin
        if (address < 32'd64) bios_out <= rom[address[5:0]];
        else                  bios_out <= 32'd0;
    end

    bios_fetch #(.ADDR_W(32), .BIOS_DEPTH(64), .RESET_PC(0)) dut (
        .clk_auto    (clk),
        .reset       (reset),
        .address     (address),
        .biosOut     (bios_out),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted),
        .fault       (fault)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the bench #1 after the last reset edge: the DUT is in its
    // first post-reset cycle (cycle 0).
    task automatic reset_dut();
        reset       = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Called at a negedge; steps cycles until instr_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            tick();
            smp();
            n++;
        end
        if (instr_valid !== 1'b1) chk("wait_valid_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    function automatic logic [31:0] next_pc_of(input logic [31:0] pc, input logic [31:0] word);
`ifdef BIOS_FETCH_PREDECODE_EN
        if (word[31:26] == T_JUMP) return {6'd0, word[25:0]};
`endif
        return pc + 32'd1;
    endfunction

    typedef struct {
        logic        rdr_en;
        logic [31:0] rdr_pc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int exp_pc;
        int pend;
        bit ev;
        logic [31:0] w;
        logic [31:0] tgt;

        for (int i = 0; i < 64; i++) rom[i] = {6'b000001, 26'(32'h100 + i * 3)};
        rom[0]  = 32'h68000001;
        rom[1]  = 32'h33DE0003;
        rom[17] = 32'h68000006;
        rom[22] = 32'h74000000;

        // cycle-by-cycle: reset latency, 3-cycle throughput, 4-cycle stall
        vecs[0]  = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         32'd0, 32'd0};
        vecs[1]  = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         32'd0, 32'd0};
        vecs[2]  = '{1'b0, 32'd0, 1'b1, 1'b1, 32'h68000001, 32'd0, 32'd0};
        vecs[3]  = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         32'd0, 32'd1};
        vecs[4]  = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         32'd0, 32'd1};
        vecs[5]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h33DE0003, 32'd1, 32'd1};
        vecs[6]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h33DE0003, 32'd1, 32'd1};
        vecs[7]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h33DE0003, 32'd1, 32'd1};
        vecs[8]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h33DE0003, 32'd1, 32'd1};
        vecs[9]  = '{1'b0, 32'd0, 1'b1, 1'b1, 32'h33DE0003, 32'd1, 32'd1};
        vecs[10] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         32'd0, 32'd2};

        // ---------------- reset state ----------------
        reset_dut();
        smp();
        chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault",  {31'd0, fault}, 32'd0);
        chk("rst_instr",  instr, 32'd0);
        chk("rst_ipc",    instr_pc, 32'd0);

        // ---------------- table ----------------
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            if (i > 0) tick();
            redirect_en = vecs[i].rdr_en;
            redirect_pc = vecs[i].rdr_pc;
            instr_ready = vecs[i].rdy;
            smp();
            chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("tbl%0d_addr", i), address, vecs[i].e_addr);
            if (vecs[i].e_valid) begin
                chk($sformatf("tbl%0d_instr", i), instr, vecs[i].e_instr);
                chk($sformatf("tbl%0d_ipc", i), instr_pc, vecs[i].e_ipc);
            end
            $display("cycle %0d: valid=%0b instr=%h ipc=%0d addr=%0d", i, instr_valid, instr, instr_pc, address);
        end

        // ---------------- redirect during capture ----------------
        reset_dut();
        instr_ready = 1'b0;
        smp();
        tick();                         // cycle 1: capture
        redirect_en = 1'b1;
        redirect_pc = 32'd6;
        smp();
        chk("rdc_valid_c1", {31'd0, instr_valid}, 32'd0);
        tick();                         // cycle 2: issue at 6
        redirect_en = 1'b0;
        smp();
        chk("rdc_valid_c2", {31'd0, instr_valid}, 32'd0);
        chk("rdc_addr_c2", address, 32'd6);
        wait_valid(n);
        chk("rdc_latency", n, 32'd2);
        chk("rdc_ipc", instr_pc, 32'd6);
        chk("rdc_instr", instr, rom[6]);
        $display("redirect: presented ipc=%0d instr=%h", instr_pc, instr);

        // ---------------- HLT ----------------
        redirect_en = 1'b1;
        redirect_pc = 32'd22;
        tick();
        redirect_en = 1'b0;
        smp();
        wait_valid(n);
        chk("hlt_ipc", instr_pc, 32'd22);
        chk("hlt_instr", instr, 32'h74000000);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        smp();
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_valid", {31'd0, instr_valid}, 32'd0);
        redirect_en = 1'b1;
        redirect_pc = 32'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            smp();
            chk("hlt_hold_halted", {31'd0, halted}, 32'd1);
            chk("hlt_hold_valid", {31'd0, instr_valid}, 32'd0);
            chk("hlt_hold_addr", address, 32'd22);
        end
        $display("hlt: halted=%0b addr=%0d", halted, address);
        reset_dut();
        smp();
        chk("hlt_rst_addr", address, 32'd0);
        chk("hlt_rst_halted", {31'd0, halted}, 32'd0);
        chk("hlt_rst_instr", instr, 32'd0);

        // ---------------- fault on out-of-range redirect ----------------
        reset_dut();
        redirect_en = 1'b1;
        redirect_pc = 32'd64;
        smp();
        tick();                         // cycle 1: issue at 64
        redirect_en = 1'b0;
        smp();
        chk("flt_addr", address, 32'd64);
        chk("flt_early", {31'd0, fault}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            smp();
            chk("flt_fault", {31'd0, fault}, 32'd1);
            chk("flt_valid", {31'd0, instr_valid}, 32'd0);
            chk("flt_halted", {31'd0, halted}, 32'd0);
        end
        $display("fault: fault=%0b addr=%0d", fault, address);

        // ---------------- jump predecode ----------------
        reset_dut();
        redirect_en = 1'b1;
        redirect_pc = 32'd17;
        tick();
        redirect_en = 1'b0;
        smp();
        wait_valid(n);
        chk("jmp_ipc0", instr_pc, 32'd17);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        smp();
        wait_valid(n);
`ifdef BIOS_FETCH_PREDECODE_EN
        tgt = 32'd6;
`else
        tgt = 32'd18;
`endif
        chk("jmp_ipc1", instr_pc, tgt);
        chk("jmp_instr1", instr, rom[tgt[5:0]]);
        $display("jump: next ipc=%0d", instr_pc);

        // ---------------- randomized ----------------
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[31:26] == T_HLT) w[31:26] = 6'b000000;
            if (w[31:26] == T_JUMP) w[25:0] = 26'($urandom_range(0, 59));
            rom[i] = w;
        end
        reset_dut();
        exp_pc = 0;
        pend   = 3;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) tick();
            redirect_en = ($urandom_range(0, 9) == 0) || (exp_pc >= 60);
            redirect_pc = 32'($urandom_range(0, 59));
            instr_ready = ($urandom_range(0, 2) != 0);
            smp();
            if (pend > 0) pend--;
            ev = (pend == 0);
            chk("rnd_valid", {31'd0, instr_valid}, {31'd0, ev});
            if (ev) begin
                chk("rnd_ipc", instr_pc, 32'(exp_pc));
                chk("rnd_instr", instr, rom[exp_pc[5:0]]);
            end
            if (redirect_en) begin
                exp_pc = int'(redirect_pc);
                pend   = 3;
            end else if (ev && instr_ready) begin
                $display("accept ipc=%0d instr=%h", exp_pc, rom[exp_pc[5:0]]);
                exp_pc = int'(next_pc_of(32'(exp_pc), rom[exp_pc[5:0]]));
                pend   = 3;
            end
        end
        chk("rnd_halted", {31'd0, halted}, 32'd0);
        chk("rnd_fault", {31'd0, fault}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
